execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage pipelined RISC-V core. It sits directly downstream of decode_cycle and consumes its ID/EX register outputs.
- Performs operand forwarding, the ALU operation, branch resolution (beq) and branch-target generation.
- Registers the results into the EX/MEM pipeline register that feeds memory_cycle.
- Branch decision (PCSrcE) and target (PCTargetE) are combinational and go back to the fetch stage.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- RegWriteE  in  1  register-write control from decode
- ALUSrcE  in  1  0: SrcB = forwarded RD2; 1: SrcB = Imm_Ext_E
- MemWriteE  in  1  store control
- ResultSrcE  in  1  0: ALU result to writeback; 1: memory data to writeback
- BranchE  in  1  instruction is beq
- ALUControlE  in  3  ALU operation select
- RD1_E  in  XLEN  rs1 value from register file
- RD2_E  in  XLEN  rs2 value from register file
- Imm_Ext_E  in  XLEN  sign-extended immediate
- RD_E  in  REG_ADDR_W  destination register index
- PCE  in  XLEN  PC of this instruction
- PCPlus4E  in  XLEN  PC+4 of this instruction
- ForwardAE  in  2  SrcA select: 00 RD1_E, 01 ResultW, 10 ALUResultM
- ForwardBE  in  2  pre-ALUSrc B select, same encoding
- ResultW  in  XLEN  writeback-stage result
- HoldM  in  1  1: EX/MEM register keeps its value
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  XLEN  PCE + Imm_Ext_E (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls
- RD_M  out  REG_ADDR_W  registered destination index
- ALUResultM  out  XLEN  registered ALU result
- WriteDataM  out  XLEN  registered forwarded rs2 (store data)
- PCPlus4M  out  XLEN  registered PC+4

Behaviour:
- Reset: rst is sampled only on a rising clk edge.
  - When rst=1 at an edge, every M output becomes 0 (RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M).
  - rst takes priority over HoldM.
  - Reset mid-operation discards the in-flight instruction; no partial state survives.
- Forwarding:
  - SrcA = mux(ForwardAE).
  - WriteDataE = mux(ForwardBE).
  - SrcB = ALUSrcE ? Imm_Ext_E : WriteDataE.
  - Code 11 selects RD1_E / RD2_E (treated as 00).
  - The ALUResultM forwarding source is this block's own registered output.
- ALU (combinational, XLEN-bit, carries beyond XLEN discarded, wrap-around):
  - 000 add A+B
  - 001 sub A-B
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt: signed A<B gives 1, else 0, zero-extended
  - 110 sltu: unsigned compare
  - 111 pass B
- ZeroE: 1 when the ALU result is 0.
- Branch:
  - PCSrcE = BranchE & ZeroE.
  - PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN.
  - Both are valid in the same cycle as the E inputs (zero latency).
- EX/MEM register: one-cycle latency. On each rising edge:
  - rst=1: clear all M outputs.
  - else HoldM=1: hold all M outputs.
  - else load: RegWriteE→RegWriteM, MemWriteE→MemWriteM, ResultSrcE→ResultSrcM, RD_E→RD_M, ALU result→ALUResultM, WriteDataE→WriteDataM, PCPlus4E→PCPlus4M.
- Bubbles: flushes are injected upstream as all-zero controls; the block needs no special handling for them.
- HoldM with a changing ALUResultM:
  - While HoldM=1, ALUResultM is stable.
  - Forwarding still uses the held value.
- No x propagation: all outputs are defined after the first reset edge.

Test Plan:
1. Reset and hold:
   - Drive RegWriteE=1, RD_E=7, add 5+3; assert rst for 1 edge → all M outputs 0.
   - Release rst, one edge → ALUResultM=8, RD_M=7, RegWriteM=1.
2. ALU sweep:
   - A=0xFFFF_FFFF, B=1:
     - add → 0 (wrap)
     - sub → 0xFFFF_FFFE
     - xor → 0xFFFF_FFFE
     - slt → 1 (signed -1<1)
     - sltu → 0
   - A=0x0000_00F0, B=0x0000_000F:
     - and → 0
     - or → 0xFF
   - pass B → 0xF.
3. Forwarding:
   - Load ALUResultM=0x100, drive ResultW=0x200, RD1_E=1, RD2_E=2, add.
   - Expected results:
     - ForwardAE=10, ForwardBE=01 → 0x300 next edge
     - ForwardAE=11 → uses RD1_E: 0x201
   - With ALUSrcE=1, Imm_Ext_E=4, ForwardBE=01 → WriteDataM=0x200 and SrcB=4.
4. Branch:
   - BranchE=1, sub, RD1_E=RD2_E=9, PCE=0x40, Imm_Ext_E=0xFFFF_FFF8 → PCSrcE=1 and PCTargetE=0x38 in the same cycle.
   - With RD2_E=8 → PCSrcE=0.
   - BranchE=0 with equal operands → PCSrcE=0.
5. HoldM:
   - Load ALUResultM=0xAA; assert HoldM for 3 edges while the E inputs change → M outputs stay 0xAA with unchanged controls.
   - Deassert HoldM → new value loads on the next edge.
   - Assert rst together with HoldM → outputs clear.
6. Store path:
   - MemWriteE=1, RegWriteE=0, ALUSrcE=1, RD1_E=0x1000, Imm_Ext_E=8, RD2_E=0xDEAD → ALUResultM=0x1008, WriteDataM=0xDEAD, MemWriteM=1, RegWriteM=0.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution, branch target,
// and the EX/MEM pipeline register feeding the memory stage.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   RegWriteE..PCPlus4E    ID/EX controls and operands from decode
//   ForwardAE/ForwardBE    operand source selects (00 reg, 01 WB, 10 MEM)
//   ResultW                writeback-stage result for forwarding
//   HoldM                  freeze the EX/MEM register
//   PCSrcE, PCTargetE      combinational branch decision and target
//   *M outputs             registered EX/MEM bundle
module execute_cycle #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ALUSrcE,
    input  logic                  MemWriteE,
    input  logic                  ResultSrcE,
    input  logic                  BranchE,
    input  logic [2:0]            ALUControlE,
    input  logic [XLEN-1:0]       RD1_E,
    input  logic [XLEN-1:0]       RD2_E,
    input  logic [XLEN-1:0]       Imm_Ext_E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [XLEN-1:0]       ResultW,
    input  logic                  HoldM,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [XLEN-1:0]       PCPlus4M
);

    logic [XLEN-1:0]       w_src_a;
    logic [XLEN-1:0]       w_wdata;
    logic [XLEN-1:0]       w_src_b;
    logic [XLEN-1:0]       w_alu;
    logic                  w_zero;

    logic                  r_regwrite;
    logic                  r_memwrite;
    logic                  r_resultsrc;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_alu;
    logic [XLEN-1:0]       r_wdata;
    logic [XLEN-1:0]       r_pcplus4;

    // Forwarding from MEM uses our own registered result, so a held
    // EX/MEM register keeps supplying the held value.
    always_comb begin
        w_src_a = RD1_E;
        case (ForwardAE)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = r_alu;
            default: w_src_a = RD1_E;
        endcase
    end

    always_comb begin
        w_wdata = RD2_E;
        case (ForwardBE)
            2'b01:   w_wdata = ResultW;
            2'b10:   w_wdata = r_alu;
            default: w_wdata = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_wdata;

    always_comb begin
        w_alu = '0;
        case (ALUControlE)
            3'b000: w_alu = w_src_a + w_src_b;
            3'b001: w_alu = w_src_a - w_src_b;
            3'b010: w_alu = w_src_a & w_src_b;
            3'b011: w_alu = w_src_a | w_src_b;
            3'b100: w_alu = w_src_a ^ w_src_b;
            3'b101: w_alu = {{(XLEN-1){1'b0}},
                             $signed(w_src_a) < $signed(w_src_b)};
            3'b110: w_alu = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
            3'b111: w_alu = w_src_b;
            default: w_alu = '0;
        endcase
    end

    assign w_zero    = (w_alu == '0);
    assign PCSrcE    = BranchE & w_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_resultsrc <= 1'b0;
            r_rd        <= '0;
            r_alu       <= '0;
            r_wdata     <= '0;
            r_pcplus4   <= '0;
        end else if (!HoldM) begin
            r_regwrite  <= RegWriteE;
            r_memwrite  <= MemWriteE;
            r_resultsrc <= ResultSrcE;
            r_rd        <= RD_E;
            r_alu       <= w_alu;
            r_wdata     <= w_wdata;
            r_pcplus4   <= PCPlus4E;
        end
    end

    assign RegWriteM  = r_regwrite;
    assign MemWriteM  = r_memwrite;
    assign ResultSrcM = r_resultsrc;
    assign RD_M       = r_rd;
    assign ALUResultM = r_alu;
    assign WriteDataM = r_wdata;
    assign PCPlus4M   = r_pcplus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: reset, ALU sweep, forwarding,
// branch, hold and store path with hand-computed expected values.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        HoldM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int n_vec = 0;
    int n_err = 0;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .HoldM(HoldM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, ".RegWriteM"}, {31'd0, RegWriteM}, 32'd0);
        chk({tag, ".MemWriteM"}, {31'd0, MemWriteM}, 32'd0);
        chk({tag, ".ResultSrcM"}, {31'd0, ResultSrcM}, 32'd0);
        chk({tag, ".RD_M"}, {27'd0, RD_M}, 32'd0);
        chk({tag, ".ALUResultM"}, ALUResultM, 32'd0);
        chk({tag, ".WriteDataM"}, WriteDataM, 32'd0);
        chk({tag, ".PCPlus4M"}, PCPlus4M, 32'd0);
    endtask

    logic [2:0]  ops  [8];
    logic [31:0] opa  [8];
    logic [31:0] opb  [8];
    logic [31:0] expv [8];

    initial begin
        rst = 1'b1; HoldM = 1'b0;
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; ALUControlE = 3'b000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
        ResultW = 0; RD_E = 0; ForwardAE = 0; ForwardBE = 0;

        // 1. reset then release
        RegWriteE = 1; RD_E = 5'd7; RD1_E = 5; RD2_E = 3;
        PCPlus4E = 32'h24;
        step();
        chk_m_zero("rst");
        rst = 1'b0;
        step();
        chk("rel.alu", ALUResultM, 32'd8);
        chk("rel.rd", {27'd0, RD_M}, 32'd7);
        chk("rel.rw", {31'd0, RegWriteM}, 32'd1);
        chk("rel.pc4", PCPlus4M, 32'h24);

        // 2. ALU sweep
        ops[0] = 3'b000; opa[0] = 32'hFFFF_FFFF; opb[0] = 1;
        expv[0] = 32'h0;
        ops[1] = 3'b001; opa[1] = 32'hFFFF_FFFF; opb[1] = 1;
        expv[1] = 32'hFFFF_FFFE;
        ops[2] = 3'b100; opa[2] = 32'hFFFF_FFFF; opb[2] = 1;
        expv[2] = 32'hFFFF_FFFE;
        ops[3] = 3'b101; opa[3] = 32'hFFFF_FFFF; opb[3] = 1;
        expv[3] = 32'h1;
        ops[4] = 3'b110; opa[4] = 32'hFFFF_FFFF; opb[4] = 1;
        expv[4] = 32'h0;
        ops[5] = 3'b010; opa[5] = 32'hF0; opb[5] = 32'hF;
        expv[5] = 32'h0;
        ops[6] = 3'b011; opa[6] = 32'hF0; opb[6] = 32'hF;
        expv[6] = 32'hFF;
        ops[7] = 3'b111; opa[7] = 32'hF0; opb[7] = 32'hF;
        expv[7] = 32'hF;
        for (int i = 0; i < 8; i++) begin
            ALUControlE = ops[i]; RD1_E = opa[i]; RD2_E = opb[i];
            step();
            chk($sformatf("alu%0d", i), ALUResultM, expv[i]);
        end

        // 3. forwarding
        ALUControlE = 3'b000; RD1_E = 32'h100; RD2_E = 0;
        step();
        chk("fwd.load", ALUResultM, 32'h100);
        ResultW = 32'h200; RD1_E = 1; RD2_E = 2;
        ForwardAE = 2'b10; ForwardBE = 2'b01;
        step();
        chk("fwd.mem_wb", ALUResultM, 32'h300);
        chk("fwd.wdata", WriteDataM, 32'h200);
        ForwardAE = 2'b11;
        step();
        chk("fwd.code11", ALUResultM, 32'h201);
        ForwardAE = 2'b00; ALUSrcE = 1; Imm_Ext_E = 4;
        step();
        chk("fwd.imm_alu", ALUResultM, 32'h5);
        chk("fwd.imm_wd", WriteDataM, 32'h200);
        ForwardBE = 2'b11; ALUSrcE = 0;
        step();
        chk("fwd.b11", ALUResultM, 32'h3);

        // 4. branch
        ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0;
        BranchE = 1; ALUControlE = 3'b001;
        RD1_E = 9; RD2_E = 9; PCE = 32'h40; Imm_Ext_E = 32'hFFFF_FFF8;
        #1;
        chk("br.taken", {31'd0, PCSrcE}, 32'd1);
        chk("br.target", PCTargetE, 32'h38);
        RD2_E = 8;
        #1;
        chk("br.ne", {31'd0, PCSrcE}, 32'd0);
        RD2_E = 9; BranchE = 0;
        #1;
        chk("br.nobr", {31'd0, PCSrcE}, 32'd0);

        // 5. hold
        ALUControlE = 3'b000; RD1_E = 32'hAA; RD2_E = 0;
        RegWriteE = 1; ResultSrcE = 1; RD_E = 5'd3; PCPlus4E = 32'h10;
        step();
        chk("hold.load", ALUResultM, 32'hAA);
        HoldM = 1;
        for (int i = 0; i < 3; i++) begin
            RD1_E = 32'h55 + i; RD_E = 5'd9; RegWriteE = 0;
            ResultSrcE = 0; MemWriteE = 1; PCPlus4E = 32'h80;
            step();
            chk($sformatf("hold%0d.alu", i), ALUResultM, 32'hAA);
            chk($sformatf("hold%0d.rd", i), {27'd0, RD_M}, 32'd3);
            chk($sformatf("hold%0d.ctl", i),
                {29'd0, RegWriteM, MemWriteM, ResultSrcM}, 32'b101);
            chk($sformatf("hold%0d.pc4", i), PCPlus4M, 32'h10);
        end
        // forwarding sees the held value
        ForwardAE = 2'b10; RD2_E = 1;
        step();
        chk("hold.fwd", ALUResultM, 32'hAA);
        HoldM = 0;
        step();
        chk("unhold.alu", ALUResultM, 32'hAB);
        chk("unhold.rd", {27'd0, RD_M}, 32'd9);
        chk("unhold.ctl", {29'd0, RegWriteM, MemWriteM, ResultSrcM},
            32'b010);
        ForwardAE = 0; rst = 1; HoldM = 1;
        step();
        chk_m_zero("rsthold");
        rst = 0; HoldM = 0;

        // 6. store path
        MemWriteE = 1; RegWriteE = 0; ALUSrcE = 1; ResultSrcE = 0;
        RD1_E = 32'h1000; Imm_Ext_E = 8; RD2_E = 32'hDEAD;
        ALUControlE = 3'b000; RD_E = 0; PCPlus4E = 32'h44;
        step();
        chk("st.alu", ALUResultM, 32'h1008);
        chk("st.wd", WriteDataM, 32'hDEAD);
        chk("st.mw", {31'd0, MemWriteM}, 32'd1);
        chk("st.rw", {31'd0, RegWriteM}, 32'd0);
        chk("st.pc4", PCPlus4M, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
